pak_dsp_rif: RTL
================

Name: pak_dsp_rif

Overview:
- APB3 register-interface responder that owns all run-time configuration of the pak_dsp core.
- Drives the `bypass` and `coeffs` inputs of the interpolator (duc) and decimator (ddc) chains.
- Software writes coefficients into shadow banks. A per-chain commit copies shadow to active atomically, only while that chain reports idle, so a filter never sees a half-updated coefficient set.
- Sits beside the datapath inside pak_dsp. It is the bus-facing end of the `bypass`/`coeffs` configuration interface those chains consume.

Parameters:
- COEFF_WIDTH, 16, width of each coefficient; must be ≤ 32.
- N_COEFFS_0, 8, taps in first half-band stage of each chain.
- N_COEFFS_1, 8, taps in second half-band stage of each chain; N_COEFFS_0+N_COEFFS_1 ≤ 16 (elaboration-time assertion).
- ADDR_WIDTH, 8, APB address width (byte addresses).

Ports:
- clk  in  1  core clock
- arst_n  in  1  asynchronous active-low reset
- psel  in  1  APB select
- penable  in  1  APB enable (access phase)
- pwrite  in  1  1 = write
- paddr  in  ADDR_WIDTH  byte address; bits [1:0] ignored
- pwdata  in  32  write data
- pready  out  1  transfer complete
- prdata  out  32  read data, valid when pready=1
- pslverr  out  1  error response, valid when pready=1
- duc_idle  in  1  duc has no sample in flight
- ddc_idle  in  1  ddc has no sample in flight
- duc_bypass  out  2  per-stage bypass for duc
- ddc_bypass  out  2  per-stage bypass for ddc
- duc_coeffs  out  (N_COEFFS_0+N_COEFFS_1)*COEFF_WIDTH  active duc coefficients, coeff i at [i*COEFF_WIDTH +: COEFF_WIDTH]
- ddc_coeffs  out  same  active ddc coefficients

Behaviour:
- Clocking and reset: single clock `clk`; reset `arst_n` is asynchronous and active-low.
- Reset values:
  - pready=0, prdata=0, pslverr=0.
  - duc_bypass and ddc_bypass = 2'b11.
  - All shadow and active coefficients = 0.
  - Commit-pending flags = 0; FSM in IDLE.
- Address map (byte addresses):
  - 0x00 ID: RO, 0x5044_5350.
  - 0x04 CTRL: RW.
    - bit0 duc_commit (W1S, reads 0).
    - bit1 ddc_commit (W1S, reads 0).
    - [5:4] duc_bypass.
    - [9:8] ddc_bypass.
    - Bypass fields take effect immediately.
  - 0x08 STATUS: RO; bit0 duc_pending, bit1 ddc_pending.
  - 0x40+4*i: duc shadow coeff i.
  - 0x80+4*i: ddc shadow coeff i.
  - Valid i range: 0 ≤ i < N_COEFFS_0+N_COEFFS_1.
- APB FSM, states IDLE → WAIT → RESP (one wait state):
  - IDLE → WAIT when psel && penable. Decode paddr/pwrite and register the result.
  - WAIT → RESP unconditionally. Perform the write here; register prdata and pslverr.
  - RESP: pready=1 for exactly one cycle, then → IDLE.
  - Access latency: pready rises 2 cycles after the first cycle with psel && penable.
- Write semantics:
  - Coefficient writes store pwdata[COEFF_WIDTH-1:0].
  - Reads return the shadow value zero-extended to 32 bits; active values are not readable.
- Error response (pslverr=1 in RESP, no state change, prdata=0):
  - unmapped address, including coefficient index ≥ N_COEFFS_0+N_COEFFS_1;
  - write to ID or STATUS.
- Commit:
  - A write with CTRL bit0 or bit1 = 1 sets the matching pending flag at the WAIT edge.
  - On any edge where pending && idle for that chain: copy the whole shadow bank to active and clear pending on the same edge.
  - Minimum write-to-active latency is 1 cycle after the WAIT edge.
- Boundary conditions:
  - Commit while already pending: no-op, stays pending.
  - Shadow write on the same edge as a copy: the copy uses the pre-write shadow; the new value lands only in shadow.
  - Commit and copy of the other chain are fully independent.
  - idle low indefinitely: pending persists and active is unchanged.
  - Reset mid-transfer: pready drops asynchronously and the transfer is lost; the master restarts it.
  - psel deasserted in WAIT: the transaction still completes (APB protocol violation, not guarded).

Decomposition:
- Package pak_dsp_rif_pkg holds:
  - address offsets (ID, CTRL, STATUS, DUC_BASE, DDC_BASE);
  - the ID constant;
  - CTRL bit positions;
  - the FSM enum {IDLE, WAIT, RESP}.
- Sub-module pak_dsp_coeff_bank: shadow array, active array, pending flag, commit/idle copy logic. Instantiated twice, once for duc and once for ddc.

Test Plan:
- Reset, then read 0x00 → pready on 3rd access cycle, prdata=0x5044_5350, pslverr=0. Read 0x04 → 0x0000_0330.
- Write 0x40 = 0x0001_ABCD with duc_idle=0, then CTRL=0x0000_0001:
  - STATUS reads 0x1 and duc_coeffs[15:0] stays 0.
  - Raise duc_idle: one edge later duc_coeffs[15:0]=0xABCD and STATUS reads 0.
- Write 0xBC (i=15) = 0x7FFF, commit ddc with ddc_idle=1 → ddc_coeffs[255:240]=0x7FFF. duc_coeffs unchanged.
- Write 0x0000_0010 to CTRL → duc_bypass=2'b01 and ddc_bypass=2'b00 the cycle after WAIT; no pending flag set.
- Write 0xC0, write 0x08, read 0x3C-beyond-range (N=8+4 config, 0x70) → each gets pslverr=1, prdata=0, and no register changes.
- Assert arst_n=0 during WAIT of a coefficient write → pready=0 immediately. After release, the coefficient reads 0 and bypass reads 2'b11.

Source files
------------

// File: rtl/pak_dsp_rif_pkg.sv
// Shared constants and types for the pak_dsp register interface: address map,
// ID value, CTRL field positions and the APB responder state machine.
package pak_dsp_rif_pkg;

  localparam logic [31:0] ID_OFFS     = 32'h0000_0000;
  localparam logic [31:0] CTRL_OFFS   = 32'h0000_0004;
  localparam logic [31:0] STATUS_OFFS = 32'h0000_0008;
  localparam logic [31:0] DUC_BASE    = 32'h0000_0040;
  localparam logic [31:0] DDC_BASE    = 32'h0000_0080;

  localparam logic [31:0] ID_VALUE = 32'h5044_5350;

  localparam int CTRL_DUC_COMMIT  = 0;
  localparam int CTRL_DDC_COMMIT  = 1;
  localparam int CTRL_DUC_BYP_LSB = 4;
  localparam int CTRL_DDC_BYP_LSB = 8;

  localparam logic [1:0] BYPASS_RESET = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } apb_state_e;

  // SEL_ERR covers unmapped addresses and writes to read-only registers.
  typedef enum logic [2:0] {
    SEL_ID,
    SEL_CTRL,
    SEL_STATUS,
    SEL_DUC,
    SEL_DDC,
    SEL_ERR
  } reg_sel_e;

  function automatic logic [31:0] ctrl_readback(input logic [1:0] duc_bp,
                                                input logic [1:0] ddc_bp);
    logic [31:0] v;
    v = '0;
    v[CTRL_DUC_BYP_LSB +: 2] = duc_bp;
    v[CTRL_DDC_BYP_LSB +: 2] = ddc_bp;
    return v;
  endfunction

endpackage

// File: rtl/pak_dsp_coeff_bank.sv
// One chain's coefficient storage: software-visible shadow bank, filter-facing
// active bank, and the pending flag that gates the shadow-to-active copy.
module pak_dsp_coeff_bank #(
  parameter int COEFF_WIDTH = 16,
  parameter int N_COEFFS    = 16,
  parameter int IDX_W       = 4
) (
  input  logic                            clk,
  input  logic                            arst_n,
  input  logic                            wr_en,
  input  logic [IDX_W-1:0]                wr_idx,
  input  logic [COEFF_WIDTH-1:0]          wr_data,
  input  logic                            commit,
  input  logic                            idle,
  input  logic [IDX_W-1:0]                rd_idx,
  output logic [COEFF_WIDTH-1:0]          rd_data,
  output logic                            pending,
  output logic [N_COEFFS*COEFF_WIDTH-1:0] active_flat
);

  logic [COEFF_WIDTH-1:0] shadow_q [N_COEFFS];
  logic [COEFF_WIDTH-1:0] shadow_d [N_COEFFS];
  logic [COEFF_WIDTH-1:0] active_q [N_COEFFS];
  logic [COEFF_WIDTH-1:0] active_d [N_COEFFS];
  logic                   pending_q;
  logic                   pending_d;

  // The copy reads shadow_q, so a shadow write landing on the copy edge only
  // reaches the shadow bank. A fresh commit re-arms pending even on a copy edge.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (pending_q && idle) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (commit) begin
      pending_d = 1'b1;
    end
    if (wr_en) begin
      shadow_d[wr_idx] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      shadow_q  <= '{default: '0};
      active_q  <= '{default: '0};
      pending_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign rd_data = shadow_q[rd_idx];
  assign pending = pending_q;

  for (genvar i = 0; i < N_COEFFS; i++) begin : g_flat
    assign active_flat[i*COEFF_WIDTH +: COEFF_WIDTH] = active_q[i];
  end

endmodule

// File: rtl/pak_dsp_rif.sv
// APB3 responder owning the bypass and coefficient configuration of the duc and
// ddc chains. Every access takes one wait state: IDLE -> WAIT -> RESP.
module pak_dsp_rif #(
  parameter int COEFF_WIDTH = 16,
  parameter int N_COEFFS_0  = 8,
  parameter int N_COEFFS_1  = 8,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                                          clk,
  input  logic                                          arst_n,
  input  logic                                          psel,
  input  logic                                          penable,
  input  logic                                          pwrite,
  input  logic [ADDR_WIDTH-1:0]                         paddr,
  input  logic [31:0]                                   pwdata,
  output logic                                          pready,
  output logic [31:0]                                   prdata,
  output logic                                          pslverr,
  input  logic                                          duc_idle,
  input  logic                                          ddc_idle,
  output logic [1:0]                                    duc_bypass,
  output logic [1:0]                                    ddc_bypass,
  output logic [(N_COEFFS_0+N_COEFFS_1)*COEFF_WIDTH-1:0] duc_coeffs,
  output logic [(N_COEFFS_0+N_COEFFS_1)*COEFF_WIDTH-1:0] ddc_coeffs
);

  import pak_dsp_rif_pkg::*;

  localparam int N_TOTAL = N_COEFFS_0 + N_COEFFS_1;
  localparam int IDX_W   = (N_TOTAL > 1) ? $clog2(N_TOTAL) : 1;

  if (COEFF_WIDTH > 32 || N_TOTAL > 16) begin : g_param_check
    $error("pak_dsp_rif: COEFF_WIDTH must be <= 32 and N_COEFFS_0+N_COEFFS_1 <= 16");
  end

  apb_state_e       state_q, state_d;
  reg_sel_e         sel_q, sel_d;
  logic             write_q, write_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       duc_bp_q, duc_bp_d;
  logic [1:0]       ddc_bp_q, ddc_bp_d;
  logic             pready_q, pready_d;
  logic [31:0]      prdata_q, prdata_d;
  logic             pslverr_q, pslverr_d;

  logic [31:0]      addr_al;
  logic [31:0]      duc_off;
  logic [31:0]      ddc_off;
  reg_sel_e         dec_sel;
  logic [IDX_W-1:0] dec_idx;

  logic                   duc_wr, ddc_wr;
  logic                   duc_commit, ddc_commit;
  logic [COEFF_WIDTH-1:0] duc_rd, ddc_rd;
  logic                   duc_pending, ddc_pending;
  logic                   unused_wdata;

  // Write direction is folded into the decode so RO writes surface as errors.
  always_comb begin
    addr_al = 32'(paddr) & ~32'h3;
    duc_off = addr_al - DUC_BASE;
    ddc_off = addr_al - DDC_BASE;
    dec_sel = SEL_ERR;
    dec_idx = '0;
    if (addr_al == ID_OFFS) begin
      dec_sel = pwrite ? SEL_ERR : SEL_ID;
    end else if (addr_al == CTRL_OFFS) begin
      dec_sel = SEL_CTRL;
    end else if (addr_al == STATUS_OFFS) begin
      dec_sel = pwrite ? SEL_ERR : SEL_STATUS;
    end else if (addr_al >= DUC_BASE && duc_off < 32'(4 * N_TOTAL)) begin
      dec_sel = SEL_DUC;
      dec_idx = duc_off[IDX_W+1:2];
    end else if (addr_al >= DDC_BASE && ddc_off < 32'(4 * N_TOTAL)) begin
      dec_sel = SEL_DDC;
      dec_idx = ddc_off[IDX_W+1:2];
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    write_d    = write_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    duc_bp_d   = duc_bp_q;
    ddc_bp_d   = ddc_bp_q;
    pready_d   = 1'b0;
    prdata_d   = '0;
    pslverr_d  = 1'b0;
    duc_wr     = 1'b0;
    ddc_wr     = 1'b0;
    duc_commit = 1'b0;
    ddc_commit = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && penable) begin
          state_d = WAIT;
          sel_d   = dec_sel;
          write_d = pwrite;
          idx_d   = dec_idx;
          wdata_d = pwdata;
        end
      end
      WAIT: begin
        state_d  = RESP;
        pready_d = 1'b1;
        if (sel_q == SEL_ERR) begin
          pslverr_d = 1'b1;
        end else if (write_q) begin
          case (sel_q)
            SEL_CTRL: begin
              duc_bp_d   = wdata_q[CTRL_DUC_BYP_LSB +: 2];
              ddc_bp_d   = wdata_q[CTRL_DDC_BYP_LSB +: 2];
              duc_commit = wdata_q[CTRL_DUC_COMMIT];
              ddc_commit = wdata_q[CTRL_DDC_COMMIT];
            end
            SEL_DUC: duc_wr = 1'b1;
            SEL_DDC: ddc_wr = 1'b1;
            default: ;
          endcase
        end else begin
          case (sel_q)
            SEL_ID:     prdata_d = ID_VALUE;
            SEL_CTRL:   prdata_d = ctrl_readback(duc_bp_q, ddc_bp_q);
            SEL_STATUS: prdata_d = {30'b0, ddc_pending, duc_pending};
            SEL_DUC:    prdata_d = 32'(duc_rd);
            SEL_DDC:    prdata_d = 32'(ddc_rd);
            default:    prdata_d = '0;
          endcase
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= IDLE;
      sel_q     <= SEL_ERR;
      write_q   <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      duc_bp_q  <= BYPASS_RESET;
      ddc_bp_q  <= BYPASS_RESET;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      write_q   <= write_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      duc_bp_q  <= duc_bp_d;
      ddc_bp_q  <= ddc_bp_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  pak_dsp_coeff_bank #(
    .COEFF_WIDTH (COEFF_WIDTH),
    .N_COEFFS    (N_TOTAL),
    .IDX_W       (IDX_W)
  ) u_duc_bank (
    .clk         (clk),
    .arst_n      (arst_n),
    .wr_en       (duc_wr),
    .wr_idx      (idx_q),
    .wr_data     (wdata_q[COEFF_WIDTH-1:0]),
    .commit      (duc_commit),
    .idle        (duc_idle),
    .rd_idx      (idx_q),
    .rd_data     (duc_rd),
    .pending     (duc_pending),
    .active_flat (duc_coeffs)
  );

  pak_dsp_coeff_bank #(
    .COEFF_WIDTH (COEFF_WIDTH),
    .N_COEFFS    (N_TOTAL),
    .IDX_W       (IDX_W)
  ) u_ddc_bank (
    .clk         (clk),
    .arst_n      (arst_n),
    .wr_en       (ddc_wr),
    .wr_idx      (idx_q),
    .wr_data     (wdata_q[COEFF_WIDTH-1:0]),
    .commit      (ddc_commit),
    .idle        (ddc_idle),
    .rd_idx      (idx_q),
    .rd_data     (ddc_rd),
    .pending     (ddc_pending),
    .active_flat (ddc_coeffs)
  );

  assign unused_wdata = ^wdata_q;

  assign pready     = pready_q;
  assign prdata     = prdata_q;
  assign pslverr    = pslverr_q;
  assign duc_bypass = duc_bp_q;
  assign ddc_bypass = ddc_bp_q;

endmodule
